pwm_multi: RTL and testbench

Parametrised successor to the single-channel pwm block in toi2s_tt_top.
- Drives NCH PWM outputs from one shared counter with a programmable period and a clock prescaler.
- Supports edge-aligned and center-aligned modes, plus per-channel enable and polarity.
- Duty, period, mode, polarity and enable are double-buffered and load only at period boundaries, using a req/ack handshake.
- Configuration comes from the register bank (rb_toi2s sys_cfg fields); outputs go to pads and debug_out.

---
 rtl/toi2s_pkg.sv | 28 ++
 rtl/pwm_multi_if.sv | 31 +++
 rtl/pwm_multi_ch.sv | 48 ++++
 rtl/pwm_multi.sv | 121 ++++++++++++
 tb/tb_pwm_multi.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/toi2s_pkg.sv
// Shared types and defaults for the toi2s PWM block and its register-bank mapping.
package toi2s_pkg;

   localparam int PWM_NCH     = 4;
   localparam int PWM_WIDTH   = 8;
   localparam int PWM_PRESC_W = 8;

   typedef enum logic {
      PWM_EDGE   = 1'b0,
      PWM_CENTER = 1'b1
   } pwm_mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } pwm_dir_e;

   // sys_cfg view of one pwm_multi instance
   typedef struct packed {
      pwm_mode_e                          mode;
      logic [PWM_WIDTH-1:0]               period;
      logic [PWM_PRESC_W-1:0]             prescale;
      logic [PWM_NCH-1:0][PWM_WIDTH-1:0]  duty;
      logic [PWM_NCH-1:0]                 ch_en;
      logic [PWM_NCH-1:0]                 polarity;
   } pwm_multi_cfg_t;

endpackage

// File: rtl/pwm_multi_if.sv
// Configuration, handshake and output bundle between the register bank and pwm_multi.
interface pwm_multi_if
   import toi2s_pkg::*;
#(
   parameter int NCH     = PWM_NCH,
   parameter int WIDTH   = PWM_WIDTH,
   parameter int PRESC_W = PWM_PRESC_W
);
   logic                   ena;
   logic                   mode;
   logic [WIDTH-1:0]       period;
   logic [PRESC_W-1:0]     prescale;
   logic [NCH*WIDTH-1:0]   duty;
   logic [NCH-1:0]         ch_en;
   logic [NCH-1:0]         polarity;
   logic                   upd_req;
   logic                   upd_ack;
   logic                   period_start;
   logic [NCH-1:0]         pwm_out;
   logic [WIDTH-1:0]       cnt_mon;

   modport master (
      output ena, mode, period, prescale, duty, ch_en, polarity, upd_req,
      input  upd_ack, period_start, pwm_out, cnt_mon
   );

   modport slave (
      input  ena, mode, period, prescale, duty, ch_en, polarity, upd_req,
      output upd_ack, period_start, pwm_out, cnt_mon
   );
endinterface

// File: rtl/pwm_multi_ch.sv
// One PWM channel: shadowed duty/enable/polarity and the registered compare output.
module pwm_multi_ch
   import toi2s_pkg::*;
#(
   parameter int WIDTH = PWM_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] cnt,
   input  logic [WIDTH-1:0] duty,
   input  logic             en,
   input  logic             pol,
   output logic             pwm
);
   logic [WIDTH-1:0] duty_sh_reg;
   logic             en_sh_reg;
   logic             pol_sh_reg;
   logic             pwm_reg;
   logic             pwm_next;

   // disabled channels park at their polarity level
   always_comb begin
      pwm_next = pol_sh_reg;
      if (en_sh_reg) begin
         pwm_next = (cnt < duty_sh_reg) ^ pol_sh_reg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         duty_sh_reg <= '0;
         en_sh_reg   <= 1'b0;
         pol_sh_reg  <= 1'b0;
         pwm_reg     <= 1'b0;
      end else begin
         pwm_reg <= pwm_next;
         if (load) begin
            duty_sh_reg <= duty;
            en_sh_reg   <= en;
            pol_sh_reg  <= pol;
         end
      end
   end

   assign pwm = pwm_reg;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaled counter (edge/center aligned), double-buffered
// configuration loaded at period boundaries via a req/ack handshake.
module pwm_multi
   import toi2s_pkg::*;
#(
   parameter int NCH     = PWM_NCH,
   parameter int WIDTH   = PWM_WIDTH,
   parameter int PRESC_W = PWM_PRESC_W
) (
   input  logic      clk,
   input  logic      reset,
   pwm_multi_if.slave bus
);
   localparam logic [WIDTH-1:0]   CNT_ONE = 1;
   localparam logic [PRESC_W-1:0] PRE_ONE = 1;

   logic [PRESC_W-1:0] pre_cnt_reg, pre_cnt_next;
   logic [PRESC_W-1:0] presc_sh_reg;
   logic [WIDTH-1:0]   cnt_reg, cnt_next;
   logic [WIDTH-1:0]   period_sh_reg;
   pwm_mode_e          mode_sh_reg;
   pwm_dir_e           dir_reg, dir_next;
   logic               pending_reg;
   logic               upd_ack_reg;
   logic               period_start_reg;
   logic               tick;
   logic               center;
   logic               boundary;
   logic               load;
   logic [NCH-1:0]     pwm_bits;

   // Center mode with P=0 degenerates to edge behaviour; P=1 ends on the way up.
   always_comb begin
      tick     = bus.ena && (pre_cnt_reg == presc_sh_reg);
      center   = (mode_sh_reg == PWM_CENTER) && (period_sh_reg != '0);
      boundary = 1'b0;
      if (center) begin
         boundary = tick && (cnt_reg == CNT_ONE)
                    && ((dir_reg == DIR_DOWN) || (period_sh_reg == CNT_ONE));
      end else begin
         boundary = tick && (cnt_reg == period_sh_reg);
      end
      load = bus.ena ? (boundary && (pending_reg || bus.upd_req))
                     : (pending_reg || bus.upd_req);
   end

   always_comb begin
      pre_cnt_next = pre_cnt_reg;
      cnt_next     = cnt_reg;
      dir_next     = dir_reg;
      if (!bus.ena || load) begin
         pre_cnt_next = '0;
         cnt_next     = '0;
         dir_next     = DIR_UP;
      end else if (tick) begin
         pre_cnt_next = '0;
         if (boundary) begin
            cnt_next = '0;
            dir_next = DIR_UP;
         end else if (center && (dir_reg == DIR_DOWN)) begin
            cnt_next = cnt_reg - CNT_ONE;
         end else if (center && (cnt_reg == period_sh_reg)) begin
            cnt_next = cnt_reg - CNT_ONE;
            dir_next = DIR_DOWN;
         end else begin
            cnt_next = cnt_reg + CNT_ONE;
         end
      end else begin
         pre_cnt_next = pre_cnt_reg + PRE_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt_reg      <= '0;
         cnt_reg          <= '0;
         dir_reg          <= DIR_UP;
         pending_reg      <= 1'b0;
         upd_ack_reg      <= 1'b0;
         period_start_reg <= 1'b0;
         period_sh_reg    <= '0;
         presc_sh_reg     <= '0;
         mode_sh_reg      <= PWM_EDGE;
      end else begin
         pre_cnt_reg      <= pre_cnt_next;
         cnt_reg          <= cnt_next;
         dir_reg          <= dir_next;
         pending_reg      <= !load && (pending_reg || bus.upd_req);
         upd_ack_reg      <= load;
         period_start_reg <= boundary;
         if (load) begin
            period_sh_reg <= bus.period;
            presc_sh_reg  <= bus.prescale;
            mode_sh_reg   <= pwm_mode_e'(bus.mode);
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         pwm_multi_ch #(
            .WIDTH (WIDTH)
         ) u_ch (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .cnt   (cnt_reg),
            .duty  (bus.duty[gi*WIDTH +: WIDTH]),
            .en    (bus.ch_en[gi]),
            .pol   (bus.polarity[gi]),
            .pwm   (pwm_bits[gi])
         );
      end
   endgenerate

   assign bus.pwm_out      = pwm_bits;
   assign bus.upd_ack      = upd_ack_reg;
   assign bus.period_start = period_start_reg;
   assign bus.cnt_mon      = cnt_reg;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: period-position reference model plus directed sequences.
module tb_pwm_multi;
   import toi2s_pkg::*;

   localparam int NCH     = 4;
   localparam int WIDTH   = 8;
   localparam int PRESC_W = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pwm_multi_if #(.NCH(NCH), .WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();

   pwm_multi #(.NCH(NCH), .WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   // reference model: shadow config plus position within the current period
   int m_pre, m_phase, m_P, m_S;
   bit m_mode, m_pend;
   int m_duty[NCH];
   bit m_en[NCH], m_pol[NCH];
   logic [NCH-1:0] e_pwm;
   bit e_ack, e_ps;

   typedef struct {
      logic [NCH*WIDTH-1:0] duty;
      logic [NCH-1:0]       en;
      logic [NCH-1:0]       pol;
      logic [NCH-1:0]       exp_pwm;
   } vec_t;
   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int plen();
      if (m_mode && m_P > 0) return 2 * m_P;
      return m_P + 1;
   endfunction

   function automatic int exp_cnt();
      if (m_mode && m_P > 0 && m_phase > m_P) return 2 * m_P - m_phase;
      return m_phase;
   endfunction

   task automatic model_reset();
      m_pre = 0; m_phase = 0; m_P = 0; m_S = 0; m_mode = 0; m_pend = 0;
      for (int i = 0; i < NCH; i++) begin
         m_duty[i] = 0; m_en[i] = 0; m_pol[i] = 0;
      end
      e_pwm = '0; e_ack = 0; e_ps = 0;
   endtask

   // advance one clock: predict, clock the DUT, compare every output
   task automatic step();
      bit tick, bnd, load;
      int c;
      c    = exp_cnt();
      tick = bus.ena && (m_pre == m_S);
      bnd  = tick && (m_phase == plen() - 1);
      load = bus.ena ? (bnd && (m_pend || bus.upd_req)) : (m_pend || bus.upd_req);
      for (int i = 0; i < NCH; i++)
         e_pwm[i] = m_en[i] ? ((c < m_duty[i]) ^ m_pol[i]) : m_pol[i];
      e_ack = load;
      e_ps  = bnd;
      if (!bus.ena || load) begin
         m_pre = 0; m_phase = 0;
      end else if (tick) begin
         m_pre = 0; m_phase = (m_phase + 1) % plen();
      end else begin
         m_pre++;
      end
      m_pend = load ? 1'b0 : (m_pend || bus.upd_req);
      if (load) begin
         m_P = int'(bus.period); m_S = int'(bus.prescale); m_mode = bus.mode;
         for (int i = 0; i < NCH; i++) begin
            m_duty[i] = int'(bus.duty[i*WIDTH +: WIDTH]);
            m_en[i]   = bus.ch_en[i];
            m_pol[i]  = bus.polarity[i];
         end
      end
      @(posedge clk);
      #1;
      bus.upd_req = 1'b0;
      chk("pwm_out", 32'(bus.pwm_out), 32'(e_pwm));
      chk("cnt_mon", 32'(bus.cnt_mon), 32'(exp_cnt()));
      chk("upd_ack", 32'(bus.upd_ack), 32'(e_ack));
      chk("period_start", 32'(bus.period_start), 32'(e_ps));
   endtask

   task automatic cfg(input bit md, input int p, input int s, input int d0, input logic [NCH-1:0] en);
      bus.ena      = 1'b0;
      bus.mode     = md;
      bus.period   = WIDTH'(p);
      bus.prescale = PRESC_W'(s);
      bus.duty     = '0;
      bus.duty[0 +: WIDTH] = WIDTH'(d0);
      bus.ch_en    = en;
      bus.polarity = '0;
      bus.upd_req  = 1'b1;
      step();
      bus.ena = 1'b1;
   endtask

   task automatic wait_cnt(input int v);
      int k = 0;
      while (int'(bus.cnt_mon) != v && k < 40) begin
         step();
         k++;
      end
      chk("wait_cnt", 32'(bus.cnt_mon), 32'(v));
   endtask

   initial begin
      int hi, ps, oth, chg, acks, k;
      logic [WIDTH-1:0] prev;
      int exp2[8] = '{1, 2, 3, 4, 3, 2, 1, 0};

      vecs[0] = '{duty: {8'd5, 8'd0, 8'd10, 8'd0},     en: 4'b0111, pol: 4'b0100, exp_pwm: 4'b0110};
      vecs[1] = '{duty: {8'd255, 8'd255, 8'd255, 8'd255}, en: 4'b1111, pol: 4'b0000, exp_pwm: 4'b1111};
      vecs[2] = '{duty: {8'd0, 8'd0, 8'd0, 8'd0},       en: 4'b0000, pol: 4'b1010, exp_pwm: 4'b1010};
      vecs[3] = '{duty: {8'd0, 8'd255, 8'd0, 8'd10},    en: 4'b1111, pol: 4'b1111, exp_pwm: 4'b1010};

      bus.ena = 0; bus.mode = 0; bus.period = '0; bus.prescale = '0;
      bus.duty = '0; bus.ch_en = '0; bus.polarity = '0; bus.upd_req = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pwm", 32'(bus.pwm_out), 0);
      chk("rst_cnt", 32'(bus.cnt_mon), 0);
      chk("rst_ack", 32'(bus.upd_ack), 0);
      chk("rst_ps", 32'(bus.period_start), 0);
      reset = 1'b0;

      // 1: edge mode, load while idle
      bus.ena = 0; bus.mode = 0; bus.period = 9; bus.prescale = 0;
      bus.duty = '0; bus.duty[0 +: WIDTH] = 3; bus.ch_en = 4'b0001; bus.polarity = '0;
      bus.upd_req = 1;
      step();
      chk("t1_ack", 32'(bus.upd_ack), 1);
      bus.ena = 1;
      hi = 0; ps = 0; oth = 0;
      repeat (20) begin
         step();
         hi += int'(bus.pwm_out[0]); ps += int'(bus.period_start); oth += int'(bus.pwm_out[3:1] != 0);
      end
      chk("t1_high", 32'(hi), 6);
      chk("t1_ps", 32'(ps), 2);
      chk("t1_other", 32'(oth), 0);

      // 2: center mode count sequence
      cfg(1, 4, 0, 2, 4'b0001);
      hi = 0;
      for (int j = 0; j < 16; j++) begin
         step();
         chk("t2_cnt", 32'(bus.cnt_mon), 32'(exp2[j % 8]));
         hi += int'(bus.pwm_out[0]);
      end
      chk("t2_high", 32'(hi), 6);

      // 3: prescaler
      cfg(0, 9, 2, 5, 4'b0001);
      hi = 0; ps = 0; chg = 0; prev = bus.cnt_mon;
      repeat (60) begin
         step();
         hi += int'(bus.pwm_out[0]); ps += int'(bus.period_start);
         chg += int'(bus.cnt_mon != prev); prev = bus.cnt_mon;
      end
      chk("t3_high", 32'(hi), 30);
      chk("t3_ps", 32'(ps), 2);
      chk("t3_changes", 32'(chg), 20);

      // 4: mid-period update waits for the boundary; repeated req absorbed
      cfg(0, 9, 0, 3, 4'b0001);
      wait_cnt(4);
      bus.duty[0 +: WIDTH] = 7;
      bus.upd_req = 1;
      step();
      step();
      bus.upd_req = 1;
      step();
      k = 0;
      while (!bus.upd_ack && k < 20) begin
         step();
         k++;
      end
      chk("t4_ack_seen", 32'(bus.upd_ack), 1);
      chk("t4_ack_ps", 32'(bus.period_start), 1);
      hi = 0; acks = 0;
      repeat (10) begin
         step();
         hi += int'(bus.pwm_out[0]); acks += int'(bus.upd_ack);
      end
      chk("t4_high", 32'(hi), 7);
      chk("t4_extra_ack", 32'(acks), 0);

      // 5: duty/polarity/enable corner vectors
      for (int v = 0; v < 4; v++) begin
         bus.ena = 0; bus.mode = 0; bus.period = 9; bus.prescale = 0;
         bus.duty = vecs[v].duty; bus.ch_en = vecs[v].en; bus.polarity = vecs[v].pol;
         bus.upd_req = 1;
         step();
         step();
         bus.ena = 1;
         repeat (12) begin
            step();
            chk("t5_pwm", 32'(bus.pwm_out), 32'(vecs[v].exp_pwm));
         end
      end

      // 6: asynchronous reset mid-period
      cfg(0, 9, 0, 7, 4'b0001);
      wait_cnt(5);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_pwm", 32'(bus.pwm_out), 0);
      chk("t6_ack", 32'(bus.upd_ack), 0);
      chk("t6_ps", 32'(bus.period_start), 0);
      chk("t6_cnt", 32'(bus.cnt_mon), 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      oth = 0;
      repeat (10) begin
         step();
         oth += int'(bus.pwm_out != 0);
      end
      chk("t6_after", 32'(oth), 0);

      // randomized traffic against the model
      for (int r = 0; r < 150; r++) begin
         bus.mode     = 1'($urandom_range(0, 1));
         bus.period   = WIDTH'($urandom_range(0, 12));
         bus.prescale = PRESC_W'($urandom_range(0, 3));
         for (int i = 0; i < NCH; i++) bus.duty[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 14));
         bus.ch_en    = NCH'($urandom);
         bus.polarity = NCH'($urandom);
         bus.ena      = ($urandom_range(0, 7) != 0);
         bus.upd_req  = ($urandom_range(0, 2) == 0);
         repeat ($urandom_range(1, 20)) begin
            step();
            if ($urandom_range(0, 15) == 0) bus.upd_req = 1;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
